// File: rtl/mseq_pkg.sv
//==============================================================================
// Module   : mseq_pkg
// Purpose  : Shared types, constants and the LFSR step function for the
//            m-sequence generator.
// Contents : mseq_state_t - generator FSM state (IDLE / RUN)
//            MSEQ_FREE     - mode value for free-running operation
//            MSEQ_ONESHOT  - mode value for a single period
//            lfsr_step()   - one Fibonacci LFSR step at a runtime width
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package mseq_pkg;

    // Widest LFSR the step function supports; narrower instances
    // zero-extend their operands and truncate the result.
    localparam int MSEQ_MAX_W = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mseq_state_t;

    localparam logic MSEQ_FREE    = 1'b0;
    localparam logic MSEQ_ONESHOT = 1'b1;

    // Fibonacci step: feedback is the XOR of all tapped stages, shifted in
    // at bit 0. Bits at or above w are cleared so a zero-extended narrow
    // state never leaks into the upper bits of the result.
    function automatic logic [MSEQ_MAX_W-1:0] lfsr_step(
        input logic [MSEQ_MAX_W-1:0] s,
        input logic [MSEQ_MAX_W-1:0] t,
        input int                    w
    );
        logic                  fb;
        logic [MSEQ_MAX_W-1:0] mask;
        fb   = ^(s & t);
        mask = (w >= MSEQ_MAX_W) ? {MSEQ_MAX_W{1'b1}}
                                 : (({{(MSEQ_MAX_W-1){1'b0}}, 1'b1} << w)
                                    - {{(MSEQ_MAX_W-1){1'b0}}, 1'b1});
        return {s[MSEQ_MAX_W-2:0], fb} & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mseq_period_cnt.sv
//==============================================================================
// Module   : mseq_period_cnt
// Purpose  : Period counter for the m-sequence generator. Counts accepted
//            LFSR steps and flags the step that completes a 2^N-1 period.
// Ports    : clk     in  1  rising-edge clock
//            rst     in  1  synchronous active-high reset
//            i_clr   in  1  restart the period (generator load)
//            i_step  in  1  an LFSR step is taken this cycle
//            o_wrap  out 1  this step is the last step of the period
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mseq_period_cnt
    import mseq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_step,
    output logic o_wrap
);

    // The counter runs 0 .. 2^N-2, i.e. 2^N-1 steps per period.
    localparam logic [WIDTH-1:0] c_period_last = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_d;

    // Combinational so the generator can raise its strobe on the same edge
    // that takes the final step; only feeds registers in the parent.
    assign o_wrap = i_step && (r_cnt == c_period_last);

    always_comb begin
        w_cnt_d = r_cnt;
        if (i_clr) begin
            w_cnt_d = '0;
        end else if (i_step) begin
            w_cnt_d = o_wrap ? '0 : (r_cnt + {{(WIDTH-1){1'b0}}, 1'b1});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mseq_gen.sv
//==============================================================================
// Module   : mseq_gen
// Purpose  : Parametrised maximal-length sequence generator with loadable
//            taps and start phase, free-run / one-shot modes, step enable,
//            end-of-period strobe with phase snapshot and zero-seed guard.
// Ports    : clk       in  1      rising-edge clock
//            rst       in  1      synchronous active-high reset
//            en        in  1      step enable (only acts in RUN)
//            load      in  1      latch fase/type_f/mode and start
//            fase      in  WIDTH  start phase (seed)
//            type_f    in  WIDTH  tap mask, bit i taps stage i
//            mode      in  1      0 free-run, 1 one-shot
//            sum       out 1      current chip (state MSB)
//            fase_new  out WIDTH  state captured at the last period end
//            control   out 1      one-cycle strobe after the period end
//            busy      out 1      generator is in RUN
//            lockup    out 1      last load carried an all-zero seed
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mseq_gen
    import mseq_pkg::*;
#(
    parameter int               WIDTH        = 4,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] fase,
    input  logic [WIDTH-1:0] type_f,
    input  logic             mode,
    output logic             sum,
    output logic [WIDTH-1:0] fase_new,
    output logic             control,
    output logic             busy,
    output logic             lockup
);

    // Forcing the MSB tap keeps the feedback dependent on the bit being
    // shifted out, so a nonzero state can never collapse to all-zero.
    localparam logic [WIDTH-1:0] c_msb_tap = {1'b1, {(WIDTH-1){1'b0}}};

    // Registered state
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_t;
    logic             r_m;
    mseq_state_t      r_state;
    logic [WIDTH-1:0] r_fase_new;
    logic             r_control;
    logic             r_lockup;

    // Next-state values
    logic [WIDTH-1:0] w_s_d;
    logic [WIDTH-1:0] w_t_d;
    logic             w_m_d;
    mseq_state_t      w_state_d;
    logic [WIDTH-1:0] w_fase_new_d;
    logic             w_control_d;
    logic             w_lockup_d;

    // Datapath helpers
    logic [MSEQ_MAX_W-1:0] w_s_ext;
    logic [MSEQ_MAX_W-1:0] w_t_ext;
    logic [WIDTH-1:0]      w_s_next;
    logic [WIDTH-1:0]      w_seed;
    logic                  w_seed_zero;
    logic                  w_step;
    logic                  w_wrap;

    assign w_s_ext  = MSEQ_MAX_W'(r_s);
    assign w_t_ext  = MSEQ_MAX_W'(r_t);
    assign w_s_next = WIDTH'(lfsr_step(w_s_ext, w_t_ext, WIDTH));

    assign w_seed_zero = (fase == '0);
    assign w_seed      = w_seed_zero ? SEED_DEFAULT : fase;

    // A load in the same cycle suppresses the step, which also keeps the
    // counter from reporting a wrap that the load is about to discard.
    assign w_step = !load && (r_state == ST_RUN) && en;

    mseq_period_cnt #(
        .WIDTH (WIDTH)
    ) u_period_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (load),
        .i_step (w_step),
        .o_wrap (w_wrap)
    );

    always_comb begin
        w_s_d        = r_s;
        w_t_d        = r_t;
        w_m_d        = r_m;
        w_state_d    = r_state;
        w_fase_new_d = r_fase_new;
        w_control_d  = 1'b0;
        w_lockup_d   = r_lockup;

        if (load) begin
            w_s_d      = w_seed;
            w_t_d      = type_f | c_msb_tap;
            w_m_d      = mode;
            w_lockup_d = w_seed_zero;
            w_state_d  = ST_RUN;
        end else if (w_step) begin
            w_s_d = w_s_next;
            if (w_wrap) begin
                w_fase_new_d = w_s_next;
                w_control_d  = 1'b1;
                if (r_m == MSEQ_ONESHOT) begin
                    w_state_d = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s        <= SEED_DEFAULT;
            r_t        <= c_msb_tap;
            r_m        <= MSEQ_FREE;
            r_state    <= ST_IDLE;
            r_fase_new <= '0;
            r_control  <= 1'b0;
            r_lockup   <= 1'b0;
        end else begin
            r_s        <= w_s_d;
            r_t        <= w_t_d;
            r_m        <= w_m_d;
            r_state    <= w_state_d;
            r_fase_new <= w_fase_new_d;
            r_control  <= w_control_d;
            r_lockup   <= w_lockup_d;
        end
    end

    assign sum      = r_s[WIDTH-1];
    assign fase_new = r_fase_new;
    assign control  = r_control;
    assign busy     = (r_state == ST_RUN);
    assign lockup   = r_lockup;

endmodule

`default_nettype wire

// File: doc/mseq_gen.md
# mseq_gen

Parametrised maximal-length (m-sequence) generator, successor to `mfun`. It provides a runtime-loadable tap mask and start phase, a free-run or one-shot mode, a step enable, an end-of-period strobe with a phase snapshot, and zero-seed lock-up protection. It feeds the spreading/sync path: `sum` is the chip stream. `control` together with `fase_new` lets downstream logic chain or re-phase generators.

## Interface
- `WIDTH`, 4, LFSR length N (2..32); sequence period is 2^N-1.
- `SEED_DEFAULT`, 1, reset state and substitute for an all-zero `fase`; must be nonzero.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  step enable; the LFSR advances one step per cycle while high in RUN.
- `load`  in  1  one-cycle request: latch `fase`, `type_f` and `mode`, then start.
- `fase`  in  WIDTH  start phase (seed).
- `type_f`  in  WIDTH  tap mask; bit i is the tap on stage i.
- `mode`  in  1  0 = free-run, 1 = one-shot (a single period).
- `sum`  out  1  current chip, equal to state MSB.
- `fase_new`  out  WIDTH  state captured at the last period end.
- `control`  out  1  one-cycle strobe at period end.
- `busy`  out  1  high while in RUN.
- `lockup`  out  1  sticky flag: the last load carried `fase`=0.

## Operation
- Registers:
  - state `s[N-1:0]`
  - latched taps `t`
  - latched mode `m`
  - period counter `cnt[N-1:0]`
  - FSM {IDLE, RUN}
- Tap latch: `t = type_f | (1<<(N-1))`. The MSB tap is forced on, so the all-zero state is unreachable from any nonzero state.
- Step (Fibonacci form): `fb = ^(s & t)`, then `s <= {s[N-2:0], fb}`. The `cnt` step value is `P = 2^N-2`.
- `load`, in any state, takes priority over stepping:
  - `s <= (fase==0) ? SEED_DEFAULT : fase`
  - `lockup <= (fase==0)`
  - `cnt <= 0`
  - latch `t` and `m`
  - go to RUN
  - no `control` is produced in the load cycle
- IDLE: `s` holds; `sum` shows the held MSB; `en` is ignored.
- RUN with `en`=1: step. Then:
  - If `cnt==P`: `cnt <= 0`, `fase_new <= next s`, `control <= 1` for the following cycle. If `m`=1, go to IDLE.
  - Otherwise `cnt <= cnt+1`.
- RUN with `en`=0: everything holds and `control` stays 0.
- The period is counter-based. `control` fires every 2^N-1 steps even for non-primitive taps. For primitive taps, `fase_new` equals the loaded seed.
- `rst`:
  - `s` = SEED_DEFAULT
  - `t` = MSB only
  - `cnt` = 0
  - FSM = IDLE
  - `fase_new` = 0, `control` = 0, `busy` = 0, `lockup` = 0
  - `sum` = MSB of SEED_DEFAULT
- `rst` mid-run aborts immediately. No `control` is produced and `fase_new` is not updated.

## Timing
- All outputs are registered or come directly from registers; there are no combinational paths from input to output.
- `load` at edge k: from k+1, `s` = seed, `busy` = 1, and `sum` = seed MSB.
- A step at edge j updates `sum` from j+1.
- The period-end step at edge j sets `control` and `fase_new` at j+1. `control` drops at j+2 unless the next step is also a period end (impossible for N≥2).
- In one-shot mode, `busy` falls at the same edge that raises `control`.
- `load` coinciding with a period-end step: the load wins and there is no `control`.
- `load` coinciding with `rst`: `rst` wins.

## Structure
- Package `mseq_pkg` holds:
  - the FSM state enum `mseq_state_t`
  - the mode constants `MSEQ_FREE` and `MSEQ_ONESHOT`
  - function `lfsr_step(s, t)`, parametrised via a WIDTH-sized argument or a localparam max width with masking
- One natural sub-module, `mseq_period_cnt`. It holds the counter, the compare against 2^N-2 and the wrap logic, and outputs `wrap`.
- Everything else stays in `mseq_gen`.

## Test plan
- N=4, `load` with `fase`=0001, `type_f`=1001, `mode`=0, `en`=1:
  - state sequence is 0011, 0111, 1111, 1110, 1101, 1010, 0101, 1011, 0110, 1100, 1001, 0010, 0100, 1000, 0001
  - first 8 `sum` values are 0,0,0,1,1,1,1,0
  - `control` pulses on the cycle after step 15 with `fase_new`=0001, then repeats every 15 cycles
- Same setup with `mode`=1:
  - exactly one `control` pulse
  - `busy` goes 1 then 0 after 15 steps
  - `sum` then holds at 0
- Toggle `en` with a 1-in-3 duty:
  - `control` spacing is 45 cycles
  - `sum` sequence is identical to the free-run case, only stretched
- `fase`=0000 load:
  - `lockup`=1 and the run starts from 0001
  - a subsequent load with `fase`=0110 clears `lockup`, and `fase_new` at the next period end is 0110
- Corner-case events:
  - assert `load` on the period-end cycle: no `control`, `cnt` restarts, and the next pulse comes 15 steps later
  - assert `rst` mid-run: all outputs return to their reset values on the next cycle
- WIDTH=5, `type_f`=10010 (taps on stages 4 and 1, i.e. `fb = s[4]^s[1]`, a primitive polynomial):
  - `control` period is 31
  - `fase_new` equals the seed
  - no state repeats within a period
